// File: rtl/bsg_cache_pkt_decode_pipe_pkg.sv
// Shared types for the cache-packet decode pipe.
//  - bsg_cache_opcode_e : 5-bit cache packet opcodes
//  - bsg_cache_decode_s : 16-bit decoded flag set (MSB..LSB as declared)
//  - lg_data_bytes()    : log2 of the data width in bytes (LM/SM size, ld/st size limit)
package bsg_cache_pkt_decode_pipe_pkg;

  typedef enum logic [4:0] {
    OpLb      = 5'b00000,
    OpLh      = 5'b00001,
    OpLw      = 5'b00010,
    OpLd      = 5'b00011,
    OpSb      = 5'b00100,
    OpSh      = 5'b00101,
    OpSw      = 5'b00110,
    OpSd      = 5'b00111,
    OpLbu     = 5'b01000,
    OpLhu     = 5'b01001,
    OpLwu     = 5'b01010,
    OpLdu     = 5'b01011,
    OpLm      = 5'b01100,
    OpSm      = 5'b01101,
    OpTagst   = 5'b10000,
    OpTagfl   = 5'b10001,
    OpTaglv   = 5'b10010,
    OpTagla   = 5'b10011,
    OpAfl     = 5'b10100,
    OpAflinv  = 5'b10101,
    OpAinv    = 5'b10110,
    OpAlock   = 5'b10111,
    OpAunlock = 5'b11000
  } bsg_cache_opcode_e;

  typedef struct packed {
    logic [1:0] size_op;
    logic       sigext;
    logic       mask_op;
    logic       ld;
    logic       st;
    logic       tagst;
    logic       tagfl;
    logic       taglv;
    logic       tagla;
    logic       afl;
    logic       aflinv;
    logic       ainv;
    logic       alock;
    logic       aunlock;
    logic       illegal;
  } bsg_cache_decode_s;

  function automatic logic [1:0] lg_data_bytes(input int unsigned data_width);
    return 2'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/bsg_cache_pkt_decode_comb.sv
// Pure combinational opcode decoder.
//  opcode_i : 5-bit cache packet opcode
//  decode_o : bsg_cache_decode_s flags; illegal opcodes give all-zero flags with illegal=1
module bsg_cache_pkt_decode_comb
  import bsg_cache_pkt_decode_pipe_pkg::*;
#(
  parameter int unsigned data_width_p = 64
) (
  input  logic [4:0]        opcode_i,
  output bsg_cache_decode_s decode_o
);

  localparam logic [1:0] LgBytes = lg_data_bytes(data_width_p);

  always_comb begin
    decode_o = '0;
    unique casez (opcode_i)
      5'b000??, 5'b001??, 5'b010??: begin
        // Access wider than the data bus cannot be served.
        if (opcode_i[1:0] > LgBytes) begin
          decode_o.illegal = 1'b1;
        end else begin
          decode_o.size_op = opcode_i[1:0];
          decode_o.sigext  = (opcode_i[4:2] == 3'b000);
          decode_o.ld      = (opcode_i[4:2] != 3'b001);
          decode_o.st      = (opcode_i[4:2] == 3'b001);
        end
      end
      OpLm: begin
        decode_o.size_op = LgBytes;
        decode_o.mask_op = 1'b1;
        decode_o.ld      = 1'b1;
      end
      OpSm: begin
        decode_o.size_op = LgBytes;
        decode_o.mask_op = 1'b1;
        decode_o.st      = 1'b1;
      end
      OpTagst:   decode_o.tagst   = 1'b1;
      OpTagfl:   decode_o.tagfl   = 1'b1;
      OpTaglv:   decode_o.taglv   = 1'b1;
      OpTagla:   decode_o.tagla   = 1'b1;
      OpAfl:     decode_o.afl     = 1'b1;
      OpAflinv:  decode_o.aflinv  = 1'b1;
      OpAinv:    decode_o.ainv    = 1'b1;
      OpAlock:   decode_o.alock   = 1'b1;
      OpAunlock: decode_o.aunlock = 1'b1;
      default:   decode_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bsg_cache_pkt_decode_pipe.sv
// Registered cache-packet decoder with a 2-entry output buffer.
//  clk_i, reset_n_i : clock, asynchronous active-low reset
//  v_i, cache_pkt_i, ready_o : input packet {opcode, addr, data, mask}, ready/valid
//  v_o, decode_o, addr_o, data_o, mask_o, yumi_i : head entry, valid/yumi
//  clear_err_i, err_count_o : saturating count of accepted illegal packets
// ready_o comes only from registered occupancy, so yumi_i has no path to ready_o.
module bsg_cache_pkt_decode_pipe
  import bsg_cache_pkt_decode_pipe_pkg::*;
#(
  parameter int unsigned addr_width_p = 39,
  parameter int unsigned data_width_p = 64,
  parameter int unsigned mask_width_p = data_width_p / 8,
  parameter int unsigned cnt_width_p  = 8
) (
  input  logic                                                  clk_i,
  input  logic                                                  reset_n_i,
  input  logic                                                  v_i,
  input  logic [5+addr_width_p+data_width_p+mask_width_p-1:0]   cache_pkt_i,
  output logic                                                  ready_o,
  output logic                                                  v_o,
  output logic [15:0]                                           decode_o,
  output logic [addr_width_p-1:0]                               addr_o,
  output logic [data_width_p-1:0]                               data_o,
  output logic [mask_width_p-1:0]                               mask_o,
  input  logic                                                  yumi_i,
  input  logic                                                  clear_err_i,
  output logic [cnt_width_p-1:0]                                err_count_o
);

  localparam int unsigned PktWidth = 5 + addr_width_p + data_width_p + mask_width_p;

  typedef struct packed {
    bsg_cache_decode_s         decode;
    logic [addr_width_p-1:0]   addr;
    logic [data_width_p-1:0]   data;
    logic [mask_width_p-1:0]   mask;
  } entry_t;

  bsg_cache_decode_s dec_in;
  entry_t            entry_in;
  entry_t            mem_q [2];
  entry_t            head;
  logic              head_q, tail_q;
  logic [1:0]        occ_q, occ_d;
  logic              ready_q;
  logic [cnt_width_p-1:0] err_q, err_d;
  logic              enq, deq;

  bsg_cache_pkt_decode_comb #(
    .data_width_p (data_width_p)
  ) u_decode (
    .opcode_i (cache_pkt_i[PktWidth-1 -: 5]),
    .decode_o (dec_in)
  );

  assign entry_in.decode = dec_in;
  assign entry_in.addr   = cache_pkt_i[mask_width_p+data_width_p +: addr_width_p];
  assign entry_in.data   = cache_pkt_i[mask_width_p +: data_width_p];
  assign entry_in.mask   = cache_pkt_i[mask_width_p-1:0];

  assign enq = v_i & ready_q;
  // Yumi without a valid head is ignored so state stays consistent.
  assign deq = yumi_i & (occ_q != 2'd0);

  always_comb begin
    occ_d = occ_q;
    unique case ({enq, deq})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (clear_err_i) begin
      err_d = (enq && dec_in.illegal) ? cnt_width_p'(1) : '0;
    end else if (enq && dec_in.illegal && !(&err_q)) begin
      err_d = err_q + cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      occ_q    <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= ~occ_d[1];
      err_q   <= err_d;
      if (enq) begin
        mem_q[tail_q] <= entry_in;
        tail_q        <= ~tail_q;
      end
      if (deq) begin
        head_q <= ~head_q;
      end
    end
  end

  assign head        = mem_q[head_q];
  assign v_o         = (occ_q != 2'd0);
  assign ready_o     = ready_q;
  assign decode_o    = head.decode;
  assign addr_o      = head.addr;
  assign data_o      = head.data;
  assign mask_o      = head.mask;
  assign err_count_o = err_q;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_cache_pkt_decode_pipe.sv
// Directed bench: instance a uses 64-bit data / 8-bit counter, instance b 32-bit data / 2-bit counter.
module tb_bsg_cache_pkt_decode_pipe;

  localparam int unsigned AW = 39;

  logic clk_i = 1'b0;
  logic reset_n_i;
  always #5 clk_i = ~clk_i;

  // Instance a
  logic            v_a, ready_a, vo_a, yumi_a, clr_a;
  logic [115:0]    pkt_a;
  logic [15:0]     dec_a;
  logic [AW-1:0]   addr_a;
  logic [63:0]     data_a;
  logic [7:0]      mask_a;
  logic [7:0]      err_a;

  // Instance b
  logic            v_b, ready_b, vo_b, yumi_b, clr_b;
  logic [79:0]     pkt_b;
  logic [15:0]     dec_b;
  logic [AW-1:0]   addr_b;
  logic [31:0]     data_b;
  logic [3:0]      mask_b;
  logic [1:0]      err_b;

  int checks = 0;
  int errors = 0;

  bsg_cache_pkt_decode_pipe #(
    .addr_width_p (AW),
    .data_width_p (64),
    .cnt_width_p  (8)
  ) u_dut_a (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_a),
    .cache_pkt_i (pkt_a),
    .ready_o     (ready_a),
    .v_o         (vo_a),
    .decode_o    (dec_a),
    .addr_o      (addr_a),
    .data_o      (data_a),
    .mask_o      (mask_a),
    .yumi_i      (yumi_a),
    .clear_err_i (clr_a),
    .err_count_o (err_a)
  );

  bsg_cache_pkt_decode_pipe #(
    .addr_width_p (AW),
    .data_width_p (32),
    .cnt_width_p  (2)
  ) u_dut_b (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_b),
    .cache_pkt_i (pkt_b),
    .ready_o     (ready_b),
    .v_o         (vo_b),
    .decode_o    (dec_b),
    .addr_o      (addr_b),
    .data_o      (data_b),
    .mask_o      (mask_b),
    .yumi_i      (yumi_b),
    .clear_err_i (clr_b),
    .err_count_o (err_b)
  );

  function automatic logic [115:0] mk_a(input logic [4:0] op, input logic [AW-1:0] addr,
                                        input logic [63:0] data, input logic [7:0] mask);
    return {op, addr, data, mask};
  endfunction

  function automatic logic [79:0] mk_b(input logic [4:0] op, input logic [AW-1:0] addr,
                                       input logic [31:0] data, input logic [3:0] mask);
    return {op, addr, data, mask};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    {v_a, yumi_a, clr_a, v_b, yumi_b, clr_b} = '0;
    pkt_a = '0;
    pkt_b = '0;
    repeat (3) step();
    checks++;
    if (vo_a !== 1'b0) begin errors++; $display("FAIL reset_v_o got %b want 0", vo_a); end
    checks++;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_a); end
    checks++;
    if (err_a !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_a); end
    #3 reset_n_i = 1'b1;
    step();
    checks++;
    if (ready_a !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", ready_a); end
    checks++;
    if (ready_b !== 1'b1) begin errors++; $display("FAIL release_ready_b got %b want 1", ready_b); end
    checks++;
    if (vo_a !== 1'b0) begin errors++; $display("FAIL release_v_o got %b want 0", vo_a); end
  endtask

  task automatic test_single();
    v_a = 1'b1;
    pkt_a = mk_a(5'b00011, 39'h12, 64'hDEAD, 8'hFF);
    step();
    v_a = 1'b0;
    checks++;
    if (vo_a !== 1'b1) begin errors++; $display("FAIL single_v_o got %b want 1", vo_a); end
    checks++;
    if (dec_a !== 16'hE800) begin errors++; $display("FAIL single_decode got %h want e800", dec_a); end
    checks++;
    if (addr_a !== 39'h12) begin errors++; $display("FAIL single_addr got %h want 12", addr_a); end
    checks++;
    if (data_a !== 64'hDEAD || mask_a !== 8'hFF) begin
      errors++; $display("FAIL single_data got %h/%h want dead/ff", data_a, mask_a);
    end
    yumi_a = 1'b1;
    step();
    yumi_a = 1'b0;
    checks++;
    if (vo_a !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", vo_a); end
  endtask

  task automatic test_back_to_back();
    v_a = 1'b1;
    pkt_a = mk_a(5'b00100, 39'h100, 64'h1, 8'h01);
    step();
    checks++;
    if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", ready_a); end
    pkt_a = mk_a(5'b01001, 39'h200, 64'h2, 8'h03);
    step();
    checks++;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL b2b_ready2 got %b want 0", ready_a); end
    pkt_a = mk_a(5'b10001, 39'h300, 64'h3, 8'h07);
    step();
    checks++;
    if (ready_a !== 1'b0 || addr_a !== 39'h100) begin
      errors++; $display("FAIL b2b_held got ready=%b addr=%h want 0/100", ready_a, addr_a);
    end
    checks++;
    if (dec_a !== 16'h0400) begin errors++; $display("FAIL b2b_dec1 got %h want 0400", dec_a); end
    yumi_a = 1'b1;
    step();
    checks++;
    if (addr_a !== 39'h200 || ready_a !== 1'b1) begin
      errors++; $display("FAIL b2b_second got addr=%h ready=%b want 200/1", addr_a, ready_a);
    end
    checks++;
    if (dec_a !== 16'h4800) begin errors++; $display("FAIL b2b_dec2 got %h want 4800", dec_a); end
    step();
    v_a = 1'b0;
    checks++;
    if (addr_a !== 39'h300 || vo_a !== 1'b1) begin
      errors++; $display("FAIL b2b_third got addr=%h v=%b want 300/1", addr_a, vo_a);
    end
    checks++;
    if (dec_a !== 16'h0100) begin errors++; $display("FAIL b2b_dec3 got %h want 0100", dec_a); end
    step();
    yumi_a = 1'b0;
    checks++;
    if (vo_a !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", vo_a); end
  endtask

  task automatic test_enq_deq_same_cycle();
    v_a = 1'b1;
    pkt_a = mk_a(5'b01100, 39'h400, 64'h4, 8'h0F);
    step();
    checks++;
    if (dec_a !== 16'hD800) begin errors++; $display("FAIL lm_decode got %h want d800", dec_a); end
    pkt_a = mk_a(5'b11000, 39'h500, 64'h5555, 8'h1F);
    yumi_a = 1'b1;
    step();
    v_a = 1'b0;
    checks++;
    if (vo_a !== 1'b1 || addr_a !== 39'h500 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle got v=%b addr=%h ready=%b want 1/500/1", vo_a, addr_a, ready_a);
    end
    checks++;
    if (dec_a !== 16'h0002 || data_a !== 64'h5555) begin
      errors++; $display("FAIL same_cycle_head got %h/%h want 0002/5555", dec_a, data_a);
    end
    step();
    yumi_a = 1'b0;
    checks++;
    if (vo_a !== 1'b0) begin errors++; $display("FAIL same_cycle_drain got %b want 0", vo_a); end
  endtask

  task automatic test_illegal();
    // 01110 falls in the LM/SM hole; 00111 is a legal 8-byte store at 64 bits.
    v_a = 1'b1;
    pkt_a = mk_a(5'b01110, 39'h600, 64'h6, 8'h00);
    step();
    pkt_a = mk_a(5'b00111, 39'h700, 64'h7, 8'hFF);
    checks++;
    if (dec_a !== 16'h0001 || err_a !== 8'd1) begin
      errors++; $display("FAIL illegal_a got dec=%h err=%0d want 0001/1", dec_a, err_a);
    end
    yumi_a = 1'b1;
    step();
    v_a = 1'b0;
    checks++;
    if (dec_a !== 16'hC400 || err_a !== 8'd1) begin
      errors++; $display("FAIL sd_a got dec=%h err=%0d want c400/1", dec_a, err_a);
    end
    step();
    yumi_a = 1'b0;

    // Instance b: 8-byte ops are illegal on a 4-byte bus; counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      v_b = 1'b1;
      pkt_b = mk_b((i % 2 == 0) ? 5'b11111 : 5'b00011, 39'(i), 32'(i), 4'hF);
      step();
      v_b = 1'b0;
      checks++;
      if (dec_b !== 16'h0001) begin
        errors++; $display("FAIL illegal_b_dec[%0d] got %h want 0001", i, dec_b);
      end
      checks++;
      if (err_b !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
        errors++; $display("FAIL illegal_b_err[%0d] got %0d want %0d", i, err_b, (i < 3) ? i + 1 : 3);
      end
      yumi_b = 1'b1;
      step();
      yumi_b = 1'b0;
    end
    v_b = 1'b1;
    clr_b = 1'b1;
    pkt_b = mk_b(5'b01111, 39'h9, 32'h9, 4'h1);
    step();
    v_b = 1'b0;
    clr_b = 1'b0;
    checks++;
    if (err_b !== 2'd1) begin errors++; $display("FAIL clear_with_illegal got %0d want 1", err_b); end
    yumi_b = 1'b1;
    clr_b = 1'b1;
    step();
    yumi_b = 1'b0;
    clr_b = 1'b0;
    checks++;
    if (err_b !== 2'd0) begin errors++; $display("FAIL clear_alone got %0d want 0", err_b); end
    v_b = 1'b1;
    pkt_b = mk_b(5'b00010, 39'hA, 32'hCAFE, 4'hF);
    step();
    v_b = 1'b0;
    checks++;
    if (dec_b !== 16'hA800 || err_b !== 2'd0) begin
      errors++; $display("FAIL lw_b got dec=%h err=%0d want a800/0", dec_b, err_b);
    end
    yumi_b = 1'b1;
    step();
    yumi_b = 1'b0;
  endtask

  task automatic test_reset_midstream();
    v_a = 1'b1;
    pkt_a = mk_a(5'b11010, 39'hB00, 64'hB, 8'h00);
    step();
    pkt_a = mk_a(5'b00000, 39'hC00, 64'hC, 8'h01);
    step();
    v_a = 1'b0;
    checks++;
    if (vo_a !== 1'b1 || ready_a !== 1'b0 || err_a !== 8'd2) begin
      errors++;
      $display("FAIL mid_full got v=%b ready=%b err=%0d want 1/0/2", vo_a, ready_a, err_a);
    end
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if (vo_a !== 1'b0 || err_a !== 8'd0 || ready_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got v=%b err=%0d ready=%b want 0/0/0", vo_a, err_a, ready_a);
    end
    @(posedge clk_i);
    #4 reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (vo_a !== 1'b0 || ready_a !== 1'b1) begin
        errors++; $display("FAIL mid_after[%0d] got v=%b ready=%b want 0/1", i, vo_a, ready_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enq_deq_same_cycle();
    test_illegal();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
